// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter that shares one device->host byte stream between NUM_REQ requesters.
// A grant is held for a whole burst (last, BURST_MAX beats or idle timeout) so bytes never interleave.
module cdc_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BURST_MAX    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_accept_o,
  output logic                 out_valid_o,
  output logic [7:0]           out_data_o,
  input  logic                 out_accept_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_INIT  = IW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic               g_valid;
  logic               g_last;
  logic               hs;
  logic               burst_hit;
  logic               tmo_hit;
  logic               rel;

  // Search starts just after the last granted requester, wrapping modulo NUM_REQ.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                          input logic [IW-1:0]      ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(req_valid_i, ptr_q);
  end

  assign g_valid = req_valid_i[gidx_q];
  assign g_last  = req_last_i[gidx_q];

  always_comb begin
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    req_accept_o = '0;
    if (state_q == ST_XFER) begin
      out_valid_o  = g_valid;
      if (g_valid) begin
        out_data_o = req_data_i[{gidx_q, 3'b000} +: 8];
      end
      req_accept_o = grant_q & {NUM_REQ{out_accept_i}};
    end
  end

  assign hs        = out_valid_o & out_accept_i;
  assign burst_hit = hs && (beat_q == BEAT_LAST);
  assign tmo_hit   = !g_valid && (tmo_q == TMO_LAST);
  assign rel       = (hs && g_last) || burst_hit || tmo_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && pick_found) begin
          state_d = ST_XFER;
          gidx_d  = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_XFER: begin
        if (hs) begin
          beat_d = beat_q + BW'(1);
        end
        tmo_d = g_valid ? '0 : tmo_q + TW'(1);
        // Release always passes through IDLE, which gives the mandatory gap cycle.
        if (rel) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_INIT;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_XFER);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: per-cycle vector table plus hand-written burst/timeout/stall/reset sequences.
module tb_cdc_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_accept_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_accept_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_tx_arbiter #(
    .NUM_REQ      (2),
    .BURST_MAX    (16),
    .IDLE_TIMEOUT (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_last_i   (req_last_i),
    .req_accept_o (req_accept_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_accept_i (out_accept_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       en;
    logic       acc;
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] eg;
    logic       eb;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] eacc;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic en, input logic acc, input logic [1:0] v,
                              input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] eg, input logic eb, input logic eov,
                              input logic [7:0] eod, input logic [1:0] eacc);
    vec_t r;
    r.en = en; r.acc = acc; r.v = v; r.l = l; r.d0 = d0; r.d1 = d1;
    r.eg = eg; r.eb = eb; r.eov = eov; r.eod = eod; r.eacc = eacc;
    return r;
  endfunction

  function automatic logic [13:0] obs();
    return {grant_o, busy_o, out_valid_o, out_data_o, req_accept_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic acc, input logic [1:0] v,
                       input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1);
    enable_i     = en;
    out_accept_i = acc;
    req_valid_i  = v;
    req_last_i   = l;
    req_data_i   = {d1, d0};
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] eb;
    logic [1:0] exp_g;
    int         k;

    // Cycle-by-cycle table: single 3-byte burst, alternating grants, enable gating, accept stall.
    tbl[0]  = mk(1, 1, 2'b01, 2'b00, 8'hA1, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[1]  = mk(1, 1, 2'b01, 2'b00, 8'hA1, 8'h00, 2'b01, 1, 1, 8'hA1, 2'b01);
    tbl[2]  = mk(1, 1, 2'b01, 2'b00, 8'hA2, 8'h00, 2'b01, 1, 1, 8'hA2, 2'b01);
    tbl[3]  = mk(1, 1, 2'b01, 2'b01, 8'hA3, 8'h00, 2'b01, 1, 1, 8'hA3, 2'b01);
    tbl[4]  = mk(1, 1, 2'b11, 2'b00, 8'hB0, 8'hC0, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[5]  = mk(1, 1, 2'b11, 2'b00, 8'hB0, 8'hC0, 2'b10, 1, 1, 8'hC0, 2'b10);
    tbl[6]  = mk(1, 1, 2'b11, 2'b10, 8'hB0, 8'hC1, 2'b10, 1, 1, 8'hC1, 2'b10);
    tbl[7]  = mk(1, 1, 2'b11, 2'b00, 8'hB0, 8'hC2, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[8]  = mk(1, 1, 2'b11, 2'b00, 8'hB0, 8'hC2, 2'b01, 1, 1, 8'hB0, 2'b01);
    tbl[9]  = mk(1, 1, 2'b11, 2'b01, 8'hB1, 8'hC2, 2'b01, 1, 1, 8'hB1, 2'b01);
    tbl[10] = mk(1, 1, 2'b11, 2'b00, 8'hB2, 8'hC2, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[11] = mk(1, 1, 2'b11, 2'b00, 8'hB2, 8'hC2, 2'b10, 1, 1, 8'hC2, 2'b10);
    tbl[12] = mk(0, 1, 2'b11, 2'b10, 8'hB2, 8'hC3, 2'b10, 1, 1, 8'hC3, 2'b10);
    tbl[13] = mk(0, 1, 2'b11, 2'b00, 8'hB2, 8'hC4, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[14] = mk(0, 1, 2'b11, 2'b00, 8'hB2, 8'hC4, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[15] = mk(1, 1, 2'b11, 2'b00, 8'hB2, 8'hC4, 2'b00, 0, 0, 8'h00, 2'b00);
    tbl[16] = mk(0, 0, 2'b11, 2'b01, 8'hB2, 8'hC4, 2'b01, 1, 1, 8'hB2, 2'b00);
    tbl[17] = mk(0, 1, 2'b11, 2'b01, 8'hB2, 8'hC4, 2'b01, 1, 1, 8'hB2, 2'b01);
    tbl[18] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 2'b00);

    rst_i = 1'b1;
    drive(1'b1, 1'b1, 2'b11, 2'b00, 8'h11, 8'h22);
    tick();
    check("reset_state", obs(), 14'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].en, tbl[i].acc, tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1);
      check($sformatf("vec%0d", i), obs(),
            {tbl[i].eg, tbl[i].eb, tbl[i].eov, tbl[i].eod, tbl[i].eacc});
      tick();
    end

    // req1 alone streams 20 bytes: 16-beat burst, one IDLE gap, then the remaining 4.
    k = 0;
    for (int c = 0; c < 22; c++) begin
      eb = 8'h40 + 8'(k);
      drive(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, eb);
      exp_g = (c == 0 || c == 17) ? 2'b00 : 2'b10;
      check($sformatf("burst_c%0d_grant", c), grant_o, exp_g);
      if (exp_g != 2'b00) begin
        check($sformatf("burst_c%0d_data", c), out_data_o, eb);
        k++;
      end
      tick();
    end
    drive(1'b1, 1'b1, 2'b00, 2'b00, 8'h00, 8'h99);
    check("novalid_outputs", {grant_o, out_valid_o, out_data_o}, {2'b10, 1'b0, 8'h00});

    // Idle timeout: req0 granted then silent for 64 cycles while req1 waits.
    do_reset();
    for (int c = 0; c < 68; c++) begin
      if (c < 2) drive(1'b1, 1'b1, 2'b01, 2'b00, 8'hE0, 8'h77);
      else       drive(1'b1, 1'b1, 2'b10, 2'b00, 8'hE0, 8'h77);
      if (c == 1) check("tmo_first_beat", {grant_o, out_data_o}, {2'b01, 8'hE0});
      if (c >= 2 && c <= 65)
        check($sformatf("tmo_hold_c%0d", c), {grant_o, out_valid_o, out_data_o}, {2'b01, 1'b0, 8'h00});
      if (c == 66) check("tmo_release", {grant_o, busy_o}, {2'b00, 1'b0});
      if (c == 67) check("tmo_regrant", {grant_o, out_data_o}, {2'b10, 8'h77});
      tick();
    end

    // Accept stall for 10 cycles mid-burst must not count beats.
    do_reset();
    for (int c = 0; c < 28; c++) begin
      if (c < 2)       drive(1'b1, 1'b1, 2'b01, 2'b00, 8'hF0, 8'h00);
      else if (c < 12) drive(1'b1, 1'b0, 2'b01, 2'b00, 8'hF1, 8'h00);
      else             drive(1'b1, 1'b1, 2'b01, 2'b00, 8'hF0 + 8'(c - 11), 8'h00);
      if (c >= 2 && c < 12)
        check($sformatf("stall_c%0d", c), obs(), {2'b01, 1'b1, 1'b1, 8'hF1, 2'b00});
      if (c == 26) check("stall_beat16", {grant_o, out_data_o}, {2'b01, 8'hFF});
      if (c == 27) check("stall_release", {grant_o, busy_o}, {2'b00, 1'b0});
      tick();
    end

    // Asynchronous reset in the middle of a burst.
    drive(1'b1, 1'b1, 2'b01, 2'b00, 8'h5A, 8'h00);
    check("pre_rst_grant", {grant_o, out_data_o}, {2'b01, 8'h5A});
    rst_i = 1'b1;
    #1;
    check("async_rst_outputs", obs(), 14'h0);
    tick();
    rst_i = 1'b0;
    #1;
    check("post_rst_idle", obs(), 14'h0);
    tick();
    check("post_rst_grant", {grant_o, out_data_o}, {2'b01, 8'h5A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
